// File: rtl/nonrestoring_divider_pkg.sv
// Shared definitions for the non-restoring divider.
//   div_state_e       : controller states
//   DefaultN          : default operand width
//   min_count_width() : smallest iteration-counter width W with 2^W > n
package nonrestoring_divider_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoadm,
    StIter,
    StFix
  } div_state_e;

  localparam int unsigned DefaultN = 16;

  function automatic int unsigned min_count_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) <= 64'(n)) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/nonrestoring_divider_addsub.sv
// (N+1)-bit add/subtract unit for the divider datapath. Purely combinational.
//   a, b : operands (two's complement, Width bits)
//   sub  : 1 -> y = a - b, 0 -> y = a + b
//   y    : result, carry out of the top bit discarded
module div_addsub #(
  parameter int unsigned Width = 17
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic             sub,
  output logic [Width-1:0] y
);

  always_comb begin
    y = sub ? (a - b) : (a + b);
  end

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential unsigned non-restoring divider, one quotient bit per clock.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request pulse, sampled only in idle; bus holds the dividend then
//   bus         : dividend in the start cycle, divisor in the next cycle
//   quot, rem   : registered results, held until the next completion
//   busy        : high from the edge after start until the done cycle
//   done        : one-cycle completion pulse
//   div_by_zero : set with done when the divisor was zero
module nonrestoring_divider
  import nonrestoring_divider_pkg::*;
#(
  parameter int unsigned N = DefaultN,
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] bus,
  output logic [N-1:0] quot,
  output logic [N-1:0] rem,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  if (W < min_count_width(N)) begin : g_bad_w
    $error("nonrestoring_divider: W too small to count N iterations");
  end

  div_state_e   state_q, state_d;
  logic [N:0]   a_q, a_d;
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] m_q, m_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [N-1:0] quot_q, quot_d;
  logic [N-1:0] rem_q, rem_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         dbz_q, dbz_d;

  logic [N:0] alu_a;
  logic [N:0] alu_y;
  logic       alu_sub;

  // Iterations operate on the shifted {A,Q}; the fix-up step adds M to A as is.
  always_comb begin
    alu_a   = (state_q == StFix) ? a_q : {a_q[N-1:0], q_q[N-1]};
    alu_sub = (state_q == StIter) && !a_q[N];
  end

  div_addsub #(
    .Width(N + 1)
  ) u_addsub (
    .a  (alu_a),
    .b  ({1'b0, m_q}),
    .sub(alu_sub),
    .y  (alu_y)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          q_d     = bus;
          busy_d  = 1'b1;
          state_d = StLoadm;
        end
      end
      StLoadm: begin
        m_d   = bus;
        a_d   = '0;
        cnt_d = W'(N);
        if (bus == '0) begin
          quot_d  = '1;
          rem_d   = q_q;
          dbz_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          dbz_d   = 1'b0;
          state_d = StIter;
        end
      end
      StIter: begin
        a_d   = alu_y;
        q_d   = {q_q[N-2:0], ~alu_y[N]};
        cnt_d = cnt_q - W'(1);
        if (cnt_q == W'(1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        // A negative partial remainder needs one restoring add of M.
        if (a_q[N]) begin
          a_d = alu_y;
        end
        quot_d  = q_q;
        rem_d   = a_q[N] ? alu_y[N-1:0] : a_q[N-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quot        = quot_q;
  assign rem         = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/nonrestoring_divider.md
Name: nonrestoring_divider

Overview:
- Sequential unsigned integer divider. It is the inverse operation of the team's Booth multiplier datapath and shares its A/Q/M register structure, its shared input bus and its down-counter termination.
- Uses non-restoring division: one quotient bit per clock, with a single final remainder correction.
- Controller FSM and datapath sit in one block. Sits beside the multiplier on the same operand bus.

Parameters:
- N, 16, operand width in bits for dividend, divisor, quotient and remainder.
- W, 5, iteration counter width. Must satisfy 2^W > N.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse, sampled only in IDLE. bus carries the dividend in the same cycle.
- bus  input  N  operand bus: dividend in the start cycle, divisor in the following cycle.
- quot  output  N  quotient, registered, held until the next completion.
- rem  output  N  remainder, registered, held until the next completion.
- busy  output  1  high from the edge after start until the cycle done is asserted.
- done  output  1  one-cycle completion pulse, registered.
- div_by_zero  output  1  registered flag, valid with done, held until the next completion.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; A, Q, M, count, quot, rem = 0; busy, done, div_by_zero = 0. Reset asserted mid-operation aborts the operation and leaves no partial result.
- Registers:
  - A: N+1 bits, signed partial remainder.
  - Q: N bits, dividend, becomes the quotient.
  - M: N bits, divisor, zero-extended to N+1 bits for the ALU.
  - count: W bits.
- IDLE: done=0. On start=1 at edge e0: Q<=bus; go to LOADM; busy<=1. start is ignored in every other state.
- LOADM (edge e1): M<=bus; A<=0; count<=N.
  - If bus==0: quot<=all ones, rem<=Q, div_by_zero<=1, done<=1, busy<=0, go to IDLE.
  - Otherwise: div_by_zero<=0, go to ITER.
- ITER, one edge per iteration:
  - Left-shift {A,Q} by one.
  - If the old A sign bit = 0, A_new = shifted A − M; else A_new = shifted A + M.
  - Q[0] <= ~A_new[N]; count<=count−1.
  - When count==1 at this edge, go to FIX.
  - Exactly N ITER edges (e2..e(N+1)).
- FIX (edge e(N+2)):
  - If A[N]=1, A<=A+M.
  - quot<=Q; rem<=corrected A[N−1:0]; done<=1; busy<=0; go to IDLE.
- Latency: done is high in the cycle after edge e(N+2), i.e. N+3 clocks after the start cycle. Divide-by-zero completes after edge e1 (2 clocks).
- done is high for exactly one cycle.
- A start presented in the same cycle that done is high is accepted, because the state is IDLE again.
- Arithmetic:
  - The ALU is N+1 bits wide; overflow out of bit N is discarded.
  - Results satisfy dividend = quot*divisor + rem, with rem < divisor, for every nonzero divisor.
- Boundaries:
  - dividend < divisor gives quot=0, rem=dividend.
  - dividend = 0 gives quot=0, rem=0.
  - divisor = 1 gives quot=dividend, rem=0.
  - Maximum operands need no extra width beyond N+1.

Decomposition:
- Shared package holds:
  - the FSM state enum (IDLE, LOADM, ITER, FIX);
  - a localparam for the default N;
  - a function computing the minimum legal W, used by an elaboration check.
- One natural sub-module: div_addsub, an (N+1)-bit add/subtract unit with a sub control input, instantiated once. It parallels the multiplier's ALU and is purely combinational.
- The FSM stays in the top module.

Test Plan:
- N=8: start with bus=100, next cycle bus=7 -> done exactly 11 clocks after start; quot=14, rem=2, div_by_zero=0; busy high for cycles 1..10.
- N=8: 255/1 -> quot=255, rem=0. Then 255/255 -> quot=1, rem=0. Then 5/9 -> quot=0, rem=5. Then 0/3 -> quot=0, rem=0.
- N=8: 200/0 -> done 2 clocks after start; quot=255, rem=200, div_by_zero=1. A following 9/4 -> quot=2, rem=1, div_by_zero=0.
- Pulse start again during ITER with bus=3 -> ignored; the running 100/7 still yields 14 r 2. Start issued in the done cycle is accepted.
- Assert rst_n low during ITER, release it -> all outputs 0, state IDLE. The next 50/6 yields quot=8, rem=2.
- Random sweep, N=8, 10k pairs -> quot*divisor+rem==dividend, rem<divisor, done width exactly 1 cycle.
